// File: rtl/alu_uart_ctrl.sv
// rtl/alu_uart_ctrl.sv - byte-stream command sequencer driving a combinational ALU
// Ports:
//   i_clk, i_reset           clock, asynchronous active-high reset
//   i_rx_data, i_rx_valid    received byte and its one-cycle valid pulse
//   i_alu_result             ALU output, combinational from o_valA/o_valB/o_opcode
//   i_tx_done                transmitter finished the current byte
//   o_valA, o_valB, o_opcode operands and opcode presented to the ALU
//   o_result                 last captured ALU result
//   o_tx_data, o_tx_start    byte to transmit and its one-cycle start pulse
//   o_busy                   frame accepted, result still being transmitted
//   o_err                    one-cycle pulse when a frame is discarded
module alu_uart_ctrl #(
  parameter int BUS_REG     = 16,
  parameter int BUS_OP      = 6,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  input  logic [BUS_REG-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [BUS_REG-1:0] o_valA,
  output logic [BUS_REG-1:0] o_valB,
  output logic [BUS_OP-1:0]  o_opcode,
  output logic [BUS_REG-1:0] o_result,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_err
);

  localparam int NBYTES = BUS_REG / 8;
  localparam int CW     = $clog2(NBYTES + 1);
  localparam int TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {RX_A, RX_B, RX_OP, EXEC, TX, WAIT_TX} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt;      // bytes received (RX) or bytes launched (TX)
  logic [TW-1:0]      tcnt;     // idle cycles since the last accepted byte
  logic [BUS_REG-1:0] sh_a, sh_b, tx_sh;

  logic frame_active, expire, op_bad, last_rx;
  logic accept, do_abort, do_load, do_exec, do_next, do_finish;

  // A frame is "open" once its first byte has arrived; only then may it time out.
  assign frame_active = (state == RX_A && cnt != '0) || state == RX_B || state == RX_OP;
  // An arriving byte on the expiry edge takes priority over the timeout.
  assign expire  = (TIMEOUT_CYC != 0) && frame_active && !i_rx_valid &&
                   (tcnt == TW'(TIMEOUT_CYC - 1));
  assign op_bad  = (BUS_OP < 8) && ((i_rx_data >> BUS_OP) != 8'd0);
  assign last_rx = (cnt == CW'(NBYTES - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= RX_A;
    else         state <= state_n;
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    do_abort  = 1'b0;
    do_load   = 1'b0;
    do_exec   = 1'b0;
    do_next   = 1'b0;
    do_finish = 1'b0;
    case (state)
      RX_A: begin
        if (i_rx_valid) begin
          accept = 1'b1;
          if (last_rx) state_n = RX_B;
        end else if (expire) begin
          do_abort = 1'b1;
          state_n  = RX_A;
        end
      end
      RX_B: begin
        if (i_rx_valid) begin
          accept = 1'b1;
          if (last_rx) state_n = RX_OP;
        end else if (expire) begin
          do_abort = 1'b1;
          state_n  = RX_A;
        end
      end
      RX_OP: begin
        if (i_rx_valid) begin
          accept = 1'b1;
          if (op_bad) begin
            do_abort = 1'b1;
            state_n  = RX_A;
          end else begin
            do_load = 1'b1;
            state_n = EXEC;
          end
        end else if (expire) begin
          do_abort = 1'b1;
          state_n  = RX_A;
        end
      end
      EXEC: begin
        do_exec = 1'b1;
        state_n = WAIT_TX;
      end
      TX: state_n = WAIT_TX;
      WAIT_TX: begin
        // A done coinciding with our own start pulse belongs to no byte of ours.
        if (i_tx_done && !o_tx_start) begin
          if (cnt == CW'(NBYTES)) begin
            do_finish = 1'b1;
            state_n   = RX_A;
          end else begin
            do_next = 1'b1;
            state_n = TX;
          end
        end
      end
      default: state_n = RX_A;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt        <= '0;
      tcnt       <= '0;
      sh_a       <= '0;
      sh_b       <= '0;
      tx_sh      <= '0;
      o_valA     <= '0;
      o_valB     <= '0;
      o_opcode   <= '0;
      o_result   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_err      <= do_abort;
      o_tx_start <= do_exec | do_next;

      if (accept && state == RX_A) sh_a <= (sh_a << 8) | BUS_REG'(i_rx_data);
      if (accept && state == RX_B) sh_b <= (sh_b << 8) | BUS_REG'(i_rx_data);

      if (do_abort || do_finish || do_load) cnt <= '0;
      else if (do_exec)                     cnt <= CW'(1);
      else if (accept)                      cnt <= last_rx ? '0 : cnt + 1'b1;
      else if (do_next)                     cnt <= cnt + 1'b1;

      if (accept || do_abort || !frame_active || TIMEOUT_CYC == 0) tcnt <= '0;
      else                                                          tcnt <= tcnt + 1'b1;

      // Operands reach the ALU together, only once the whole frame is valid.
      if (do_load) begin
        o_valA   <= sh_a;
        o_valB   <= sh_b;
        o_opcode <= i_rx_data[BUS_OP-1:0];
        o_busy   <= 1'b1;
      end

      if (do_exec) begin
        o_result  <= i_alu_result;
        o_tx_data <= i_alu_result[BUS_REG-1 -: 8];
        tx_sh     <= i_alu_result << 8;
      end

      if (do_next) begin
        o_tx_data <= tx_sh[BUS_REG-1 -: 8];
        tx_sh     <= tx_sh << 8;
      end

      if (do_finish) o_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// tb/tb_alu_uart_ctrl.sv - self-checking bench for alu_uart_ctrl
module tb_alu_uart_ctrl;

  localparam int BR = 16;
  localparam int BO = 6;
  localparam int TO = 50;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic [7:0]    i_rx_data;
  logic          i_rx_valid;
  logic [BR-1:0] i_alu_result;
  logic          i_tx_done;
  logic [BR-1:0] o_valA, o_valB, o_result;
  logic [BO-1:0] o_opcode;
  logic [7:0]    o_tx_data;
  logic          o_tx_start, o_busy, o_err;

  alu_uart_ctrl #(.BUS_REG(BR), .BUS_OP(BO), .TIMEOUT_CYC(TO)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .i_alu_result(i_alu_result), .i_tx_done(i_tx_done),
    .o_valA(o_valA), .o_valB(o_valB), .o_opcode(o_opcode), .o_result(o_result),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [BR-1:0] alu(input logic [BR-1:0] a, input logic [BR-1:0] b,
                                        input logic [BO-1:0] op);
    case (op)
      6'h20:        return a + b;
      6'h02, 6'h22: return a - b;
      6'h27:        return ~(a | b);
      default:      return '0;
    endcase
  endfunction

  assign i_alu_result = alu(o_valA, o_valB, o_opcode);

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  op;
    logic [15:0] res;
    logic        err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0, done_cnt = 0, err_cnt = 0;
  int consec_start = 0, consec_err = 0;
  logic prev_start = 1'b0, prev_err = 1'b0;
  logic [7:0] txq[$];

  logic [15:0] exp_a = 16'h0, exp_b = 16'h0, exp_res = 16'h0;
  logic [5:0]  exp_op = 6'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_tx_start) begin
      start_cnt++;
      txq.push_back(o_tx_data);
    end
    if (o_err) err_cnt++;
    if (o_tx_start && prev_start) consec_start++;
    if (o_err && prev_err) consec_err++;
    prev_start = o_tx_start;
    prev_err   = o_err;
  end

  always @(posedge i_clk) if (i_tx_done) done_cnt++;

  // Transmitter model: done three cycles after each start.
  initial begin
    i_tx_done = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_tx_start) begin
        repeat (3) @(negedge i_clk);
        i_tx_done = 1'b1;
        @(posedge i_clk);
        #1 i_tx_done = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(b[15:8]);
    send_byte(b[7:0]);
    send_byte(op);
  endtask

  task automatic wait_not_busy(input string name);
    int n = 0;
    while (o_busy && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    chk({name, "_busy_drop"}, {31'd0, o_busy}, 32'd0);
  endtask

  task automatic check_ops(input string name);
    chk({name, "_valA"}, {16'd0, o_valA}, {16'd0, exp_a});
    chk({name, "_valB"}, {16'd0, o_valB}, {16'd0, exp_b});
    chk({name, "_opcode"}, {26'd0, o_opcode}, {26'd0, exp_op});
    chk({name, "_result"}, {16'd0, o_result}, {16'd0, exp_res});
  endtask

  task automatic check_tx_bytes(input string name);
    logic [7:0] b0 = 8'h00;
    logic [7:0] b1 = 8'h00;
    if (txq.size() > 0) b0 = txq[0];
    if (txq.size() > 1) b1 = txq[1];
    chk({name, "_tx_nbytes"}, txq.size(), 32'd2);
    chk({name, "_tx_hi"}, {24'd0, b0}, {24'd0, exp_res[15:8]});
    chk({name, "_tx_lo"}, {24'd0, b1}, {24'd0, exp_res[7:0]});
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_valA"}, {16'd0, o_valA}, 32'd0);
    chk({name, "_valB"}, {16'd0, o_valB}, 32'd0);
    chk({name, "_opcode"}, {26'd0, o_opcode}, 32'd0);
    chk({name, "_result"}, {16'd0, o_result}, 32'd0);
    chk({name, "_tx_data"}, {24'd0, o_tx_data}, 32'd0);
    chk({name, "_tx_start"}, {31'd0, o_tx_start}, 32'd0);
    chk({name, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({name, "_err"}, {31'd0, o_err}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int s0, d0, e0;
    txq.delete();
    s0 = start_cnt;
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(v.a, v.b, v.op);
    if (v.err) begin
      repeat (3) @(negedge i_clk);
      chk({name, "_err_pulses"}, err_cnt - e0, 32'd1);
      chk({name, "_no_tx"}, start_cnt - s0, 32'd0);
      chk({name, "_busy"}, {31'd0, o_busy}, 32'd0);
    end else begin
      chk({name, "_busy_set"}, {31'd0, o_busy}, 32'd1);
      exp_a   = v.a;
      exp_b   = v.b;
      exp_op  = v.op[5:0];
      exp_res = v.res;
      wait_not_busy(name);
      chk({name, "_starts"}, start_cnt - s0, 32'd2);
      chk({name, "_dones"}, done_cnt - d0, 32'd2);
      chk({name, "_no_err"}, err_cnt - e0, 32'd0);
      check_tx_bytes(name);
    end
    check_ops(name);
  endtask

  vec_t vecs[8];

  initial begin
    int n, s0, e0;
    vec_t v;

    vecs[0] = '{a: 16'h0005, b: 16'h0003, op: 8'h20, res: 16'h0008, err: 1'b0};
    vecs[1] = '{a: 16'h0010, b: 16'h0001, op: 8'h02, res: 16'h000F, err: 1'b0};
    vecs[2] = '{a: 16'h00F0, b: 16'h000F, op: 8'h27, res: 16'hFF00, err: 1'b0};
    vecs[3] = '{a: 16'h1234, b: 16'h5678, op: 8'hC0, res: 16'h0000, err: 1'b1};
    vecs[4] = '{a: 16'h1234, b: 16'h0001, op: 8'h20, res: 16'h1235, err: 1'b0};
    vecs[5] = '{a: 16'hFFFF, b: 16'h0001, op: 8'h20, res: 16'h0000, err: 1'b0};
    vecs[6] = '{a: 16'h0001, b: 16'h0002, op: 8'h3F, res: 16'h0000, err: 1'b0};
    vecs[7] = '{a: 16'hABCD, b: 16'h1111, op: 8'h40, res: 16'h0000, err: 1'b1};

    i_reset    = 1'b1;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    check_all_zero("reset");
    i_reset = 1'b0;
    @(negedge i_clk);
    check_all_zero("post_reset");

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Idle timeout after two bytes of A.
    e0 = err_cnt;
    s0 = start_cnt;
    send_byte(8'h00);
    send_byte(8'h05);
    n = 0;
    while (!o_err && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk("timeout_cycles", n, 32'd50);
    repeat (2) @(negedge i_clk);
    chk("timeout_err_pulses", err_cnt - e0, 32'd1);
    chk("timeout_no_tx", start_cnt - s0, 32'd0);
    check_ops("timeout");
    v = '{a: 16'h0001, b: 16'h0001, op: 8'h20, res: 16'h0002, err: 1'b0};
    run_vec(v, "after_timeout");

    // Bytes arriving while the result is being sent are dropped.
    txq.delete();
    e0 = err_cnt;
    send_frame(16'h0005, 16'h0003, 8'h20);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'h20);
    chk("drop_busy_during", {31'd0, o_busy}, 32'd1);
    exp_a = 16'h0005; exp_b = 16'h0003; exp_op = 6'h20; exp_res = 16'h0008;
    wait_not_busy("drop");
    check_tx_bytes("drop");
    chk("drop_no_err", err_cnt - e0, 32'd0);
    v = '{a: 16'h0007, b: 16'h0002, op: 8'h02, res: 16'h0005, err: 1'b0};
    run_vec(v, "after_drop");

    // Asynchronous reset while waiting for the first byte to finish.
    s0 = start_cnt;
    send_frame(16'h0100, 16'h0200, 8'h20);
    n = 0;
    while (start_cnt == s0 && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    chk("rst_first_start", start_cnt - s0, 32'd1);
    @(negedge i_clk);
    #2 i_reset = 1'b1;
    #1 check_all_zero("rst_async");
    repeat (5) @(negedge i_clk);
    i_reset = 1'b0;
    txq.delete();
    s0 = start_cnt;
    repeat (20) @(negedge i_clk);
    chk("rst_no_stale_tx", start_cnt - s0, 32'd0);
    exp_a = 16'h0; exp_b = 16'h0; exp_op = 6'h0; exp_res = 16'h0;
    v = '{a: 16'h0002, b: 16'h0003, op: 8'h20, res: 16'h0005, err: 1'b0};
    run_vec(v, "after_reset");

    chk("tx_start_consecutive", consec_start, 32'd0);
    chk("err_consecutive", consec_err, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
